// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back cache with a block-wide next-level port.
// Optional feature macro CACHE_WRITE_ALLOCATE_EN: store misses allocate instead of writing around.

module set_assoc_cache #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned WAYS            = 2,
    parameter int unsigned SET_BITS        = 2,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic                            cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]           cpu_req_addr,
    input  logic [31:0]                     cpu_req_wdata,
    output logic                            cpu_resp_valid,
    output logic [31:0]                     cpu_resp_rdata,
    output logic                            mem_req_valid,
    output logic                            mem_req_write,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    output logic [32*WORDS_PER_BLOCK-1:0]   mem_req_wdata,
    output logic [WORDS_PER_BLOCK-1:0]      mem_req_wmask,
    input  logic                            mem_resp_ready,
    input  logic [32*WORDS_PER_BLOCK-1:0]   mem_resp_rdata
);

    localparam int unsigned WOFF     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFF_BITS = WOFF + 2;
    localparam int unsigned TAG_BITS = ADDR_WIDTH - SET_BITS - WOFF - 2;
    localparam int unsigned SETS     = 1 << SET_BITS;
    localparam int unsigned WAY_BITS = $clog2(WAYS);
    localparam int unsigned BLK_BITS = 32 * WORDS_PER_BLOCK;
    localparam int unsigned WA_BITS  = ADDR_WIDTH - 2;

`ifdef CACHE_WRITE_ALLOCATE_EN
    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
`else
    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WRITEAROUND} state_t;
`endif

    state_t state;

    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic [BLK_BITS-1:0]  data_q  [SETS][WAYS];
    logic [WAY_BITS-1:0]  ptr_q   [SETS];

    logic                 req_write;
    logic [WA_BITS-1:0]   req_addr;
    logic [31:0]          req_wdata;
    logic [WAY_BITS-1:0]  vic_way;
    logic                 vic_from_ptr;

    logic [TAG_BITS-1:0]  req_tag;
    logic [SET_BITS-1:0]  req_set;
    logic [WOFF-1:0]      req_word;
    logic [WOFF+4:0]      lane;

    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic                 inv_found;
    logic [WAY_BITS-1:0]  inv_way;
    logic [WAY_BITS-1:0]  miss_way;
    logic [BLK_BITS-1:0]  hit_blk;
    logic [BLK_BITS-1:0]  hit_blk_wr;
    logic [31:0]          hit_word;
    logic [BLK_BITS-1:0]  fill_blk;
    logic [31:0]          fill_word;
    logic [ADDR_WIDTH-1:0] blk_addr;
    logic [ADDR_WIDTH-1:0] vic_addr;
`ifndef CACHE_WRITE_ALLOCATE_EN
    logic [BLK_BITS-1:0]  wa_data;
    logic [WORDS_PER_BLOCK-1:0] wa_mask;
`endif

    // Byte offset is irrelevant for word accesses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_req_addr[1:0];

    assign req_word = req_addr[WOFF-1:0];
    assign req_set  = req_addr[WOFF +: SET_BITS];
    assign req_tag  = req_addr[WA_BITS-1 -: TAG_BITS];
    assign lane     = {req_word, 5'd0};

    // Lookup of the latched set, victim choice and data lane preparation.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!valid_q[req_set][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        miss_way = inv_found ? inv_way : ptr_q[req_set];

        hit_blk             = data_q[req_set][hit_way];
        hit_word            = hit_blk[lane +: 32];
        hit_blk_wr          = hit_blk;
        hit_blk_wr[lane +: 32] = req_wdata;

        fill_blk  = mem_resp_rdata;
        fill_word = mem_resp_rdata[lane +: 32];
`ifdef CACHE_WRITE_ALLOCATE_EN
        if (req_write) begin
            fill_blk[lane +: 32] = req_wdata;
        end
`else
        wa_data             = '0;
        wa_data[lane +: 32] = req_wdata;
        wa_mask             = '0;
        wa_mask[req_word]   = 1'b1;
`endif

        blk_addr = {req_tag, req_set, OFF_BITS'(0)};
        vic_addr = {tag_q[req_set][miss_way], req_set, OFF_BITS'(0)};
    end

    // Controller, arrays and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_write  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            mem_req_wmask  <= '0;
            req_write      <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            vic_way        <= '0;
            vic_from_ptr   <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_write     <= cpu_req_write;
                        req_addr      <= cpu_req_addr[ADDR_WIDTH-1:2];
                        req_wdata     <= cpu_req_wdata;
                        cpu_req_ready <= 1'b0;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_write) begin
                            data_q[req_set][hit_way]  <= hit_blk_wr;
                            dirty_q[req_set][hit_way] <= 1'b1;
                        end else begin
                            cpu_resp_rdata <= hit_word;
                        end
                        cpu_resp_valid <= 1'b1;
                        cpu_req_ready  <= 1'b1;
                        state          <= IDLE;
`ifndef CACHE_WRITE_ALLOCATE_EN
                    end else if (req_write) begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= blk_addr;
                        mem_req_wdata <= wa_data;
                        mem_req_wmask <= wa_mask;
                        state         <= WRITEAROUND;
`endif
                    end else begin
                        vic_way       <= miss_way;
                        vic_from_ptr  <= !inv_found;
                        mem_req_valid <= 1'b1;
                        if (valid_q[req_set][miss_way] && dirty_q[req_set][miss_way]) begin
                            mem_req_write <= 1'b1;
                            mem_req_addr  <= vic_addr;
                            mem_req_wdata <= data_q[req_set][miss_way];
                            mem_req_wmask <= '1;
                            state         <= WRITEBACK;
                        end else begin
                            mem_req_write <= 1'b0;
                            mem_req_addr  <= blk_addr;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= '0;
                            state         <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_resp_ready) begin
                        dirty_q[req_set][vic_way] <= 1'b0;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= blk_addr;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= '0;
                        state         <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_resp_ready) begin
                        data_q[req_set][vic_way]  <= fill_blk;
                        tag_q[req_set][vic_way]   <= req_tag;
                        valid_q[req_set][vic_way] <= 1'b1;
`ifdef CACHE_WRITE_ALLOCATE_EN
                        dirty_q[req_set][vic_way] <= req_write;
`else
                        dirty_q[req_set][vic_way] <= 1'b0;
`endif
                        if (!req_write) begin
                            cpu_resp_rdata <= fill_word;
                        end
                        // Round-robin pointer moves only when it supplied the victim.
                        if (vic_from_ptr) begin
                            ptr_q[req_set] <= ptr_q[req_set] + WAY_BITS'(1);
                        end
                        cpu_resp_valid <= 1'b1;
                        cpu_req_ready  <= 1'b1;
                        mem_req_valid  <= 1'b0;
                        mem_req_write  <= 1'b0;
                        mem_req_addr   <= '0;
                        mem_req_wdata  <= '0;
                        mem_req_wmask  <= '0;
                        state          <= IDLE;
                    end
                end
`ifndef CACHE_WRITE_ALLOCATE_EN
                WRITEAROUND: begin
                    if (mem_resp_ready) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_req_ready  <= 1'b1;
                        mem_req_valid  <= 1'b0;
                        mem_req_write  <= 1'b0;
                        mem_req_addr   <= '0;
                        mem_req_wdata  <= '0;
                        mem_req_wmask  <= '0;
                        state          <= IDLE;
                    end
                end
`endif
                default: begin
                    cpu_req_ready <= 1'b1;
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized bench for set_assoc_cache against a flat-memory view plus a tag-level placement model.
// Honours CACHE_WRITE_ALLOCATE_EN the same way the design does.

module tb_set_assoc_cache;

    localparam int unsigned AW    = 32;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned SETS  = 4;
    localparam int unsigned WORDS = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic               cpu_req_valid;
    logic               cpu_req_ready;
    logic               cpu_req_write;
    logic [AW-1:0]      cpu_req_addr;
    logic [31:0]        cpu_req_wdata;
    logic               cpu_resp_valid;
    logic [31:0]        cpu_resp_rdata;
    logic               mem_req_valid;
    logic               mem_req_write;
    logic [AW-1:0]      mem_req_addr;
    logic [127:0]       mem_req_wdata;
    logic [3:0]         mem_req_wmask;
    logic               mem_resp_ready;
    logic [127:0]       mem_resp_rdata;

    set_assoc_cache #(
        .ADDR_WIDTH(AW), .WAYS(WAYS), .SET_BITS(2), .WORDS_PER_BLOCK(WORDS)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [3:0]   mask;
    } op_t;

    op_t exp_q[$];
    op_t obs_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int stab_err = 0;
    int mem_delay = -1;

    logic [31:0] flat_mem [int];
    logic [31:0] back_mem [int];

    bit m_valid [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_ptr   [SETS];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] init_word(int idx);
        return 32'(idx) * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rd_flat(int idx);
        if (flat_mem.exists(idx)) return flat_mem[idx];
        return init_word(idx);
    endfunction

    function automatic logic [31:0] rd_back(int idx);
        if (back_mem.exists(idx)) return back_mem[idx];
        return init_word(idx);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < int'(SETS); s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < int'(WAYS); w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = 0;
            end
        end
    endfunction

    // Predicts next-level traffic and updates the CPU-visible memory image.
    function automatic void model_req(bit wr, logic [31:0] addr, logic [31:0] wd, output bit hit);
        int  tag, set, word, widx, way;
        bit  from_ptr;
        op_t op;
        tag  = int'(addr >> 6);
        set  = int'((addr >> 4) & 32'd3);
        word = int'((addr >> 2) & 32'd3);
        widx = int'(addr >> 2);
        hit  = 1'b0;
        way  = -1;
        for (int w = 0; w < int'(WAYS); w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; way = w; end
        if (hit) begin
            if (wr) begin m_dirty[set][way] = 1'b1; flat_mem[widx] = wd; end
            return;
        end
`ifndef CACHE_WRITE_ALLOCATE_EN
        if (wr) begin
            op.wr = 1'b1; op.addr = addr & 32'hFFFF_FFF0;
            op.wdata = '0; op.wdata[word*32 +: 32] = wd;
            op.mask = 4'b0001 << word;
            exp_q.push_back(op);
            flat_mem[widx] = wd;
            return;
        end
`endif
        way = -1;
        for (int w = 0; w < int'(WAYS); w++)
            if (!m_valid[set][w] && way < 0) way = w;
        from_ptr = (way < 0);
        if (from_ptr) way = m_ptr[set];
        if (m_valid[set][way] && m_dirty[set][way]) begin
            op.wr = 1'b1;
            op.addr = 32'((m_tag[set][way] << 6) | (set << 4));
            for (int w = 0; w < int'(WORDS); w++)
                op.wdata[w*32 +: 32] = rd_flat(int'(op.addr >> 2) + w);
            op.mask = 4'b1111;
            exp_q.push_back(op);
        end
        op.wr = 1'b0; op.addr = addr & 32'hFFFF_FFF0; op.wdata = '0; op.mask = '0;
        exp_q.push_back(op);
        m_valid[set][way] = 1'b1;
        m_tag[set][way]   = tag;
        m_dirty[set][way] = wr;
        if (from_ptr) m_ptr[set] = (m_ptr[set] + 1) % int'(WAYS);
        if (wr) flat_mem[widx] = wd;
    endfunction

    // Next-level memory: records requests, checks they hold steady, responds after a delay.
    initial begin : mem_model
        op_t snap;
        int  dly;
        int  base;
        bit  aborted;
        mem_resp_ready = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge CLK);
            mem_resp_ready = 1'b0;
            if (mem_req_valid === 1'b1 && !RST) begin
                snap = {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wmask};
                obs_q.push_back(snap);
                dly = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 3));
                aborted = 1'b0;
                for (int i = 0; i < dly; i++) begin
                    @(negedge CLK);
                    if (RST) begin aborted = 1'b1; break; end
                    if (mem_req_valid !== 1'b1 ||
                        {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wmask} !== snap)
                        stab_err++;
                end
                if (!aborted) begin
                    base = int'(snap.addr >> 2);
                    for (int w = 0; w < int'(WORDS); w++) begin
                        if (snap.wr) begin
                            if (snap.mask[w]) back_mem[base + w] = snap.wdata[w*32 +: 32];
                        end else begin
                            mem_resp_rdata[w*32 +: 32] = rd_back(base + w);
                        end
                    end
                    mem_resp_ready = 1'b1;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        bit          hit, got;
        int          n, ncmp;
        logic [31:0] exp_rd;
        exp_q.delete();
        obs_q.delete();
        exp_rd = rd_flat(int'(addr >> 2));
        model_req(wr, addr, wd, hit);
        n = 0;
        while (cpu_req_ready !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) check("ready_timeout", 128'(cpu_req_ready), 128'(1));
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = addr; cpu_req_wdata = wd;
        @(negedge CLK);
        cpu_req_valid = 1'b0;
        got = 1'b0; n = 0;
        while (n < 300) begin
            @(negedge CLK);
            n++;
            if (cpu_resp_valid === 1'b1) begin got = 1'b1; break; end
        end
        check("resp_seen", 128'(got), 128'(1));
        rd = cpu_resp_rdata;
        if (!wr) check("rdata", 128'(rd), 128'(exp_rd));
        if (hit) check("hit_latency", 128'(n), 128'(1));
        check("mem_op_count", 128'(obs_q.size()), 128'(exp_q.size()));
        ncmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < ncmp; i++) begin
            check("mem_op_write", 128'(obs_q[i].wr), 128'(exp_q[i].wr));
            check("mem_op_addr", 128'(obs_q[i].addr), 128'(exp_q[i].addr));
            if (exp_q[i].wr) begin
                check("mem_op_wmask", 128'(obs_q[i].mask), 128'(exp_q[i].mask));
                check("mem_op_wdata", obs_q[i].wdata, exp_q[i].wdata);
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        bit          seen, resp_seen;
        int          n;
        RST = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_ready", 128'(cpu_req_ready), 128'(1));
        check("rst_mem_valid", 128'(mem_req_valid), 128'(0));
        check("rst_resp_valid", 128'(cpu_resp_valid), 128'(0));
        check("rst_resp_rdata", 128'(cpu_resp_rdata), 128'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Cold miss then hit in the same block.
        do_req(1'b0, 32'h10, 32'h0, rd);
        do_req(1'b0, 32'h14, 32'h0, rd);
        // Store hit then readback.
        do_req(1'b1, 32'h18, 32'hDEAD_BEEF, rd);
        do_req(1'b0, 32'h18, 32'h0, rd);
        check("store_hit_readback", 128'(rd), 128'(32'hDEAD_BEEF));
        // Fill the second way, then evict the dirty first way.
        do_req(1'b0, 32'h50, 32'h0, rd);
        do_req(1'b0, 32'h90, 32'h0, rd);
        // Store miss handling, then load of the same word.
        do_req(1'b1, 32'h200, 32'h1234, rd);
        do_req(1'b0, 32'h200, 32'h0, rd);
        check("store_miss_readback", 128'(rd), 128'(32'h1234));

        // Long next-level latency: request must stay put.
        mem_delay = 20;
        do_req(1'b0, 32'h300, 32'h0, rd);
        check("mem_req_stable", 128'(stab_err), 128'(0));

        // Reset while a block read is outstanding.
        mem_delay = 40;
        resp_seen = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h340;
        @(negedge CLK);
        cpu_req_valid = 1'b0;
        seen = 1'b0; n = 0;
        while (n < 100) begin
            @(negedge CLK);
            n++;
            if (cpu_resp_valid === 1'b1) resp_seen = 1'b1;
            if (mem_req_valid === 1'b1 && mem_req_write === 1'b0) begin seen = 1'b1; break; end
        end
        check("t5_alloc_seen", 128'(seen), 128'(1));
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        if (cpu_resp_valid === 1'b1) resp_seen = 1'b1;
        check("t5_mem_valid_dropped", 128'(mem_req_valid), 128'(0));
        check("t5_ready", 128'(cpu_req_ready), 128'(1));
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (cpu_resp_valid === 1'b1) resp_seen = 1'b1;
        end
        check("t5_no_resp", 128'(resp_seen), 128'(0));
        model_reset();
        flat_mem = back_mem;
        mem_delay = -1;
        do_req(1'b0, 32'h14, 32'h0, rd);

        // Random traffic over a small footprint to force hits, conflicts and evictions.
        for (int i = 0; i < 300; i++) begin
            do_req(($urandom_range(0, 9) < 4), 32'($urandom_range(0, 63)) << 2, $urandom, rd);
        end
        check("mem_req_stable_final", 128'(stab_err), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
